// File: rtl/max7219_update_scheduler.sv
// MAX7219 traffic sequencer: power-up configuration, per-tick digit frames and brightness
// writes, serialised onto one 16-bit SPI word shifter with cs_n framing and inter-word gaps.
`timescale 1ns/1ps
module max7219_update_scheduler #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter logic [7:0]  DECODE_MASK    = 8'h3F,
  parameter logic [3:0]  INTENSITY_INIT = 4'h8,
  parameter int unsigned CS_GAP         = 16,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    frame_tick_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_mask_i,
  input  logic [3:0]              intensity_i,
  input  logic                    intensity_upd_i,
  output logic [15:0]             tx_word_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic                    tx_done_i,
  output logic                    cs_n_o,
  output logic                    busy_o,
  output logic                    init_done_o,
  output logic                    frame_done_o,
  output logic                    overrun_o,
  output logic                    timeout_err_o
);

  localparam int unsigned GAP_W      = $clog2(CS_GAP) + 1;
  localparam int unsigned TOUT_W     = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned INIT_WORDS = 5;

  typedef enum logic [2:0] {S_INIT, S_LOAD, S_SEND, S_SHIFT, S_GAP, S_IDLE} state_t;
  typedef enum logic [1:0] {SQ_INIT, SQ_FRAME, SQ_INT} seq_t;

  state_t                  state_q;
  seq_t                    seq_q;
  logic [IDX_W-1:0]        idx_q;
  logic [GAP_W-1:0]        gap_q;
  logic [TOUT_W-1:0]       tout_q;
  logic [3:0]              int_reg_q;
  logic                    int_pend_q, frame_pend_q, abort_q;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [15:0]             tx_word_q;
  logic                    tx_valid_q, cs_n_q, init_done_q, frame_done_q, overrun_q, timeout_err_q;

  logic [IDX_W-1:0]        idx_d;
  logic [15:0]             word_next_d, word_int_d, word_frame0_d, word_init0_d;

  // Word for position idx of a sequence; frame words take digit/dp sources explicitly
  function automatic logic [15:0] word_f(input seq_t seq, input logic [IDX_W-1:0] idx,
                                         input logic [4*NUM_DIGITS-1:0] dig,
                                         input logic [NUM_DIGITS-1:0] dp, input logic [3:0] ir);
    logic [15:0] w;
    w = 16'h0000;
    case (seq)
      SQ_INIT: begin
        case (idx)
          3'd0:    w = 16'h0C01;
          3'd1:    w = {8'h09, DECODE_MASK};
          3'd2:    w = {8'h0B, 8'(NUM_DIGITS - 1)};
          3'd3:    w = {8'h0A, 4'h0, ir};
          default: w = 16'h0F00;
        endcase
      end
      SQ_FRAME: w = {8'(idx) + 8'd1, dp[idx], 3'b000, dig[4*idx +: 4]};
      default:  w = {8'h0A, 4'h0, ir};
    endcase
    return w;
  endfunction

  function automatic logic [IDX_W-1:0] last_f(input seq_t seq);
    logic [IDX_W-1:0] l;
    case (seq)
      SQ_INIT:  l = IDX_W'(INIT_WORDS - 1);
      SQ_FRAME: l = IDX_W'(NUM_DIGITS - 1);
      default:  l = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    idx_d         = idx_q + IDX_W'(1);
    word_next_d   = word_f(seq_q, idx_d, dig_q, dp_q, int_reg_q);
    word_int_d    = word_f(SQ_INT, '0, dig_q, dp_q, int_reg_q);
    word_frame0_d = word_f(SQ_FRAME, '0, digits_i, dp_mask_i, int_reg_q);
    word_init0_d  = word_f(SQ_INIT, '0, dig_q, dp_q, int_reg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      seq_q         <= SQ_INIT;
      idx_q         <= '0;
      gap_q         <= '0;
      tout_q        <= '0;
      int_reg_q     <= INTENSITY_INIT;
      int_pend_q    <= 1'b0;
      frame_pend_q  <= 1'b0;
      abort_q       <= 1'b0;
      dig_q         <= '0;
      dp_q          <= '0;
      tx_word_q     <= '0;
      tx_valid_q    <= 1'b0;
      cs_n_q        <= 1'b1;
      init_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (intensity_upd_i) int_reg_q <= intensity_i;
      case (state_q)
        S_INIT: begin
          seq_q     <= SQ_INIT;
          idx_q     <= '0;
          tx_word_q <= word_init0_d;
          cs_n_q    <= 1'b0;
          state_q   <= S_LOAD;
        end
        S_LOAD: begin
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            tout_q     <= '0;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (tx_done_i) begin
            cs_n_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (tout_q == TOUT_W'(TIMEOUT - 1)) begin
            // Lost shifter: release the bus, drop the frame, then reconfigure from scratch
            cs_n_q        <= 1'b1;
            timeout_err_q <= 1'b1;
            frame_pend_q  <= 1'b0;
            init_done_q   <= 1'b0;
            abort_q       <= 1'b1;
            gap_q         <= '0;
            state_q       <= S_GAP;
          end else begin
            tout_q <= tout_q + TOUT_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(CS_GAP - 1)) begin
            if (abort_q) begin
              abort_q <= 1'b0;
              state_q <= S_INIT;
            end else if (idx_q != last_f(seq_q)) begin
              idx_q     <= idx_d;
              tx_word_q <= word_next_d;
              cs_n_q    <= 1'b0;
              state_q   <= S_LOAD;
            end else begin
              if (seq_q == SQ_INIT)  init_done_q  <= 1'b1;
              if (seq_q == SQ_FRAME) frame_done_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_IDLE: begin
          if (int_pend_q) begin
            int_pend_q <= 1'b0;
            seq_q      <= SQ_INT;
            idx_q      <= '0;
            tx_word_q  <= word_int_d;
            cs_n_q     <= 1'b0;
            state_q    <= S_LOAD;
          end else if (frame_pend_q) begin
            frame_pend_q <= 1'b0;
            dig_q        <= digits_i;
            dp_q         <= dp_mask_i;
            seq_q        <= SQ_FRAME;
            idx_q        <= '0;
            tx_word_q    <= word_frame0_d;
            cs_n_q       <= 1'b0;
            state_q      <= S_LOAD;
          end
        end
        default: state_q <= S_INIT;
      endcase
      // New requests override any clear made above in the same cycle
      if (en_i && frame_tick_i) begin
        frame_pend_q <= 1'b1;
        if (frame_pend_q) overrun_q <= 1'b1;
      end
      if (intensity_upd_i) int_pend_q <= 1'b1;
    end
  end

  assign tx_word_o     = tx_word_q;
  assign tx_valid_o    = tx_valid_q;
  assign cs_n_o        = cs_n_q;
  assign busy_o        = (state_q != S_IDLE);
  assign init_done_o   = init_done_q;
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_max7219_update_scheduler.sv
// Directed bench for max7219_update_scheduler with a simple shifter responder and word monitor.
`timescale 1ns/1ps
module tb_max7219_update_scheduler;
  localparam int CS_GAP = 16;

  logic        clk, rst_n, en_i, frame_tick_i, intensity_upd_i, tx_ready_i, tx_done_i;
  logic [23:0] digits_i;
  logic [5:0]  dp_mask_i;
  logic [3:0]  intensity_i;
  logic [15:0] tx_word_o;
  logic        tx_valid_o, cs_n_o, busy_o, init_done_o, frame_done_o, overrun_o, timeout_err_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] words[$];
  int          cyc = 0, acc_cyc = 0, fd_cnt = 0, gap_run = 0, min_gap = 1000, done_timer = 0;
  bit          acc_flag = 1'b0, auto_done = 1'b1, gap_arm = 1'b0;

  max7219_update_scheduler dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .frame_tick_i(frame_tick_i),
    .digits_i(digits_i), .dp_mask_i(dp_mask_i), .intensity_i(intensity_i),
    .intensity_upd_i(intensity_upd_i), .tx_word_o(tx_word_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i), .tx_done_i(tx_done_i), .cs_n_o(cs_n_o), .busy_o(busy_o),
    .init_done_o(init_done_o), .frame_done_o(frame_done_o), .overrun_o(overrun_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Monitor: accepted words, frame_done pulses and cs_n-high runs between words
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (tx_valid_o && tx_ready_i) begin
        words.push_back(tx_word_o);
        acc_cyc  = cyc;
        acc_flag = 1'b1;
      end
      if (frame_done_o) fd_cnt++;
      if (cs_n_o) gap_run++;
      else begin
        if (gap_arm && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
        gap_run = 0;
        if (tx_valid_o && tx_ready_i) gap_arm = 1'b1;
      end
    end
  end

  // Shifter responder: tx_done sampled 16 cycles after each accept when auto_done is set
  always @(negedge clk) begin
    tx_done_i = 1'b0;
    if (!rst_n) done_timer = 0;
    else if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) tx_done_i = 1'b1;
    end
    if (acc_flag) begin
      acc_flag = 1'b0;
      if (auto_done) done_timer = 15;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick_i = 1'b1;
    step(1);
    frame_tick_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int t = 0;
    while (quiet < 4 && t < budget) begin
      step(1);
      t++;
      if (!busy_o) quiet++; else quiet = 0;
    end
    n_checks++;
    if (quiet < 4) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy_o, budget);
    end
  endtask

  task automatic wait_first_word(input int budget);
    int t = 0;
    while (words.size() == 0 && t < budget) begin step(1); t++; end
    n_checks++;
    if (words.size() == 0) begin
      n_fail++;
      $display("FAIL first_word: no word accepted in %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = 1'b1; frame_tick_i = 1'b0; intensity_upd_i = 1'b0;
    tx_ready_i = 1'b1; digits_i = '0; dp_mask_i = '0; intensity_i = '0;
    step(3);
    n_checks += 8;
    if (cs_n_o !== 1'b1)        begin n_fail++; $display("FAIL reset_cs_n: got %0b exp 1", cs_n_o); end
    if (tx_valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_valid: got %0b exp 0", tx_valid_o); end
    if (tx_word_o !== 16'h0)    begin n_fail++; $display("FAIL reset_tx_word: got %h exp 0000", tx_word_o); end
    if (init_done_o !== 1'b0)   begin n_fail++; $display("FAIL reset_init_done: got %0b exp 0", init_done_o); end
    if (frame_done_o !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %0b exp 0", frame_done_o); end
    if (overrun_o !== 1'b0)     begin n_fail++; $display("FAIL reset_overrun: got %0b exp 0", overrun_o); end
    if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b exp 0", timeout_err_o); end
    if (busy_o !== 1'b1)        begin n_fail++; $display("FAIL reset_busy: got %0b exp 1", busy_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [15:0] exp_w[5] = '{16'h0C01, 16'h093F, 16'h0B05, 16'h0A08, 16'h0F00};
    wait_idle(1000);
    n_checks += 2;
    if (words.size() != 5) begin n_fail++; $display("FAIL init_count: got %0d exp 5", words.size()); end
    if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL init_done: got %0b exp 1", init_done_o); end
    for (int i = 0; i < 5; i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      n_checks++;
      if (got !== exp_w[i]) begin n_fail++; $display("FAIL init_word%0d: got %h exp %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_frame();
    logic [15:0] exp_w[6] = '{16'h0109, 16'h0204, 16'h0385, 16'h0402, 16'h0581, 16'h0603};
    words.delete(); fd_cnt = 0;
    digits_i = 24'h312549; dp_mask_i = 6'b010100;
    pulse_tick();
    n_checks++;
    if (cs_n_o !== 1'b1) begin n_fail++; $display("FAIL lat_cs_n_pend: got %0b exp 1", cs_n_o); end
    step(1);
    n_checks += 3;
    if (cs_n_o !== 1'b0) begin n_fail++; $display("FAIL lat_cs_n_low: got %0b exp 0", cs_n_o); end
    if (tx_word_o !== 16'h0109) begin n_fail++; $display("FAIL lat_tx_word: got %h exp 0109", tx_word_o); end
    if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_tx_valid_early: got %0b exp 0", tx_valid_o); end
    step(1);
    n_checks++;
    if (tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL lat_tx_valid: got %0b exp 1", tx_valid_o); end
    wait_idle(2000);
    n_checks += 3;
    if (words.size() != 6) begin n_fail++; $display("FAIL frame_count: got %0d exp 6", words.size()); end
    if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_cnt: got %0d exp 1", fd_cnt); end
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL frame_overrun: got %0b exp 0", overrun_o); end
    for (int i = 0; i < 6; i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      n_checks++;
      if (got !== exp_w[i]) begin n_fail++; $display("FAIL frame_word%0d: got %h exp %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_w[12] = '{16'h0109, 16'h0204, 16'h0385, 16'h0402, 16'h0581, 16'h0603,
                               16'h0107, 16'h0200, 16'h0380, 16'h0400, 16'h0580, 16'h0600};
    words.delete(); fd_cnt = 0;
    pulse_tick();
    step(30);
    digits_i = 24'h000007;
    pulse_tick();
    step(30);
    n_checks++;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_early: got %0b exp 0", overrun_o); end
    pulse_tick();
    n_checks++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %0b exp 1", overrun_o); end
    wait_idle(3000);
    n_checks += 2;
    if (words.size() != 12) begin n_fail++; $display("FAIL overrun_count: got %0d exp 12", words.size()); end
    if (fd_cnt != 2) begin n_fail++; $display("FAIL overrun_frames: got %0d exp 2", fd_cnt); end
    for (int i = 0; i < 12; i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      n_checks++;
      if (got !== exp_w[i]) begin n_fail++; $display("FAIL overrun_word%0d: got %h exp %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_int_and_frame();
    logic [15:0] exp_w[7] = '{16'h0A0F, 16'h0107, 16'h0200, 16'h0380, 16'h0400, 16'h0580, 16'h0600};
    words.delete(); fd_cnt = 0; min_gap = 1000; gap_arm = 1'b0;
    intensity_i = 4'hF; intensity_upd_i = 1'b1; frame_tick_i = 1'b1;
    step(1);
    intensity_upd_i = 1'b0; frame_tick_i = 1'b0;
    wait_idle(3000);
    n_checks += 3;
    if (words.size() != 7) begin n_fail++; $display("FAIL intfr_count: got %0d exp 7", words.size()); end
    if (fd_cnt != 1) begin n_fail++; $display("FAIL intfr_frames: got %0d exp 1", fd_cnt); end
    if (min_gap < CS_GAP || min_gap == 1000) begin
      n_fail++; $display("FAIL intfr_cs_gap: got min %0d exp >= %0d", min_gap, CS_GAP);
    end
    for (int i = 0; i < 7; i++) begin
      logic [15:0] got;
      got = (i < words.size()) ? words[i] : 16'hxxxx;
      n_checks++;
      if (got !== exp_w[i]) begin n_fail++; $display("FAIL intfr_word%0d: got %h exp %h", i, got, exp_w[i]); end
    end
  endtask

  task automatic test_enable_low();
    words.delete();
    en_i = 1'b0;
    pulse_tick();
    step(10);
    n_checks += 2;
    if (words.size() != 0) begin n_fail++; $display("FAIL en_low_words: got %0d exp 0", words.size()); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL en_low_busy: got %0b exp 0", busy_o); end
    en_i = 1'b1;
  endtask

  task automatic test_timeout();
    words.delete(); fd_cnt = 0; auto_done = 1'b0;
    pulse_tick();
    wait_first_word(100);
    while (cyc < acc_cyc + 250) step(1);
    n_checks += 2;
    if (cs_n_o !== 1'b0) begin n_fail++; $display("FAIL tout_cs_n_hold: got %0b exp 0", cs_n_o); end
    if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL tout_err_early: got %0b exp 0", timeout_err_o); end
    while (cyc < acc_cyc + 258) step(1);
    n_checks += 3;
    if (cs_n_o !== 1'b1) begin n_fail++; $display("FAIL tout_cs_n: got %0b exp 1", cs_n_o); end
    if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL tout_err: got %0b exp 1", timeout_err_o); end
    if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL tout_init_done: got %0b exp 0", init_done_o); end
    auto_done = 1'b1;
    wait_idle(2000);
    n_checks += 7;
    if (words.size() != 6) begin n_fail++; $display("FAIL tout_count: got %0d exp 6", words.size()); end
    if (words.size() > 0 && words[0] !== 16'h0107) begin n_fail++; $display("FAIL tout_word0: got %h exp 0107", words[0]); end
    if (words.size() > 1 && words[1] !== 16'h0C01) begin n_fail++; $display("FAIL tout_reinit0: got %h exp 0C01", words[1]); end
    if (words.size() > 4 && words[4] !== 16'h0A0F) begin n_fail++; $display("FAIL tout_reinit_int: got %h exp 0A0F", words[4]); end
    if (words.size() > 5 && words[5] !== 16'h0F00) begin n_fail++; $display("FAIL tout_reinit4: got %h exp 0F00", words[5]); end
    if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL tout_reinit_done: got %0b exp 1", init_done_o); end
    if (fd_cnt != 0) begin n_fail++; $display("FAIL tout_frames: got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_reset_mid_shift();
    words.delete(); auto_done = 1'b0;
    pulse_tick();
    wait_first_word(100);
    step(5);
    n_checks++;
    if (cs_n_o !== 1'b0) begin n_fail++; $display("FAIL rst_pre_cs_n: got %0b exp 0", cs_n_o); end
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (cs_n_o !== 1'b1) begin n_fail++; $display("FAIL rst_async_cs_n: got %0b exp 1", cs_n_o); end
    if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_tx_valid: got %0b exp 0", tx_valid_o); end
    if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_init_done: got %0b exp 0", init_done_o); end
    if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_tout: got %0b exp 0", timeout_err_o); end
    step(2);
    rst_n = 1'b1; auto_done = 1'b1;
    words.delete();
    wait_idle(2000);
    n_checks += 4;
    if (words.size() != 5) begin n_fail++; $display("FAIL rst_reinit_count: got %0d exp 5", words.size()); end
    if (words.size() > 0 && words[0] !== 16'h0C01) begin n_fail++; $display("FAIL rst_reinit0: got %h exp 0C01", words[0]); end
    if (words.size() > 3 && words[3] !== 16'h0A08) begin n_fail++; $display("FAIL rst_reinit_int: got %h exp 0A08", words[3]); end
    if (init_done_o !== 1'b1) begin n_fail++; $display("FAIL rst_reinit_done: got %0b exp 1", init_done_o); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_overrun();
    test_int_and_frame();
    test_enable_low();
    test_timeout();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
